// File: rtl/seven_segment_mux.sv
// seven_segment_mux
//   Time-multiplexed driver for an n_digits seven-segment display with
//   per-frame input snapshot, leading-zero blanking and PWM brightness.
//
// Ports
//   clk          : single clock, rising edge
//   reset        : asynchronous, active-high
//   num          : hex nibbles, nibble i drives digit i (digit 0 = LSD)
//   dots         : decimal-point request per digit
//   blank_lz     : leading-zero blanking enable
//   brightness   : PWM duty select, duty = (brightness+1)/2^bright_width
//   abcdefg      : active-low segments, bit 6 = a ... bit 0 = g
//   dot          : active-low decimal point
//   anodes       : active-low digit select, at most one bit low
//   frame_start  : one-cycle pulse on the cycle a new snapshot is visible
module seven_segment_mux #(
  parameter int n_digits     = 8,
  parameter int strobe_width = 10,
  parameter int bright_width = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*n_digits-1:0]   num,
  input  logic [n_digits-1:0]     dots,
  input  logic                    blank_lz,
  input  logic [bright_width-1:0] brightness,
  output logic [6:0]              abcdefg,
  output logic                    dot,
  output logic [n_digits-1:0]     anodes,
  output logic                    frame_start
);

  localparam int IW = $clog2(n_digits);

  logic [strobe_width-1:0] r_cnt;
  logic [IW-1:0]           r_idx;
  logic [4*n_digits-1:0]   r_num_sh;
  logic [n_digits-1:0]     r_dots_sh;
  logic                    r_blz_sh;
  logic [n_digits-1:0]     r_anodes;
  logic [6:0]              r_abcdefg;
  logic                    r_dot;
  logic                    r_frame_start;

  logic                    w_cnt_max;
  logic                    w_idx_last;
  logic                    w_wrap;
  logic                    w_pwm_on;
  logic [n_digits-1:0]     w_sel;
  logic [3:0]              w_nibble;
  logic                    w_dot_req;
  logic                    w_upper_zero;
  logic                    w_blank;
  logic [6:0]              w_seg;

  // Active-high a..g pattern for one hex nibble.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0:    hex_to_seg = 7'b1111110;
      4'h1:    hex_to_seg = 7'b0110000;
      4'h2:    hex_to_seg = 7'b1101101;
      4'h3:    hex_to_seg = 7'b1111001;
      4'h4:    hex_to_seg = 7'b0110011;
      4'h5:    hex_to_seg = 7'b1011011;
      4'h6:    hex_to_seg = 7'b1011111;
      4'h7:    hex_to_seg = 7'b1110000;
      4'h8:    hex_to_seg = 7'b1111111;
      4'h9:    hex_to_seg = 7'b1111011;
      4'hA:    hex_to_seg = 7'b1110111;
      4'hB:    hex_to_seg = 7'b0011111;
      4'hC:    hex_to_seg = 7'b1001110;
      4'hD:    hex_to_seg = 7'b0111101;
      4'hE:    hex_to_seg = 7'b1001111;
      default: hex_to_seg = 7'b1000111;
    endcase
  endfunction

  assign w_cnt_max  = &r_cnt;
  assign w_idx_last = (r_idx == IW'(n_digits - 1));
  assign w_wrap     = w_cnt_max && w_idx_last;

  // Upper bright_width bits of the slot counter act as the PWM ramp.
  assign w_pwm_on = (r_cnt[strobe_width-1 -: bright_width] <= brightness);

  // Per-digit select; mux out the current digit's nibble, dot request and
  // whether every nibble from this digit upward is zero.
  always_comb begin
    w_sel        = '0;
    w_nibble     = '0;
    w_dot_req    = 1'b0;
    w_upper_zero = 1'b0;
    for (int i = 0; i < n_digits; i++) begin
      w_sel[i] = (r_idx == IW'(i));
      if (w_sel[i]) begin
        w_nibble     = r_num_sh[4*i +: 4];
        w_dot_req    = r_dots_sh[i];
        w_upper_zero = ((r_num_sh >> (4*i)) == '0);
      end
    end
  end

  // Digit 0 always shows, so a zero value still reads "0".
  assign w_blank = r_blz_sh && (r_idx != '0) && w_upper_zero;
  assign w_seg   = hex_to_seg(w_nibble);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_idx     <= '0;
      r_num_sh  <= '0;
      r_dots_sh <= '0;
      r_blz_sh  <= 1'b0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (w_cnt_max)
        r_idx <= w_idx_last ? '0 : r_idx + IW'(1);
      // Snapshot only at frame boundary so mid-frame input changes never tear.
      if (w_wrap) begin
        r_num_sh  <= num;
        r_dots_sh <= dots;
        r_blz_sh  <= blank_lz;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_anodes      <= '1;
      r_abcdefg     <= '1;
      r_dot         <= 1'b1;
      r_frame_start <= 1'b0;
    end else begin
      r_anodes      <= w_pwm_on ? ~w_sel : '1;
      r_abcdefg     <= w_blank ? 7'h7F : ~w_seg;
      r_dot         <= ~w_dot_req;
      r_frame_start <= w_wrap;
    end
  end

  assign anodes      = r_anodes;
  assign abcdefg     = r_abcdefg;
  assign dot         = r_dot;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_seven_segment_mux.sv
module tb_seven_segment_mux;

  localparam int ND = 4;
  localparam int SW = 4;
  localparam int BW = 2;
  localparam int SLOT  = 1 << SW;
  localparam int FRAME = ND * SLOT;

  logic          clk = 1'b0;
  logic          reset;
  logic [4*ND-1:0] num;
  logic [ND-1:0] dots;
  logic          blank_lz;
  logic [BW-1:0] brightness;
  logic [6:0]    abcdefg;
  logic          dot;
  logic [ND-1:0] anodes;
  logic          frame_start;

  seven_segment_mux #(.n_digits(ND), .strobe_width(SW), .bright_width(BW)) dut (
    .clk(clk), .reset(reset), .num(num), .dots(dots), .blank_lz(blank_lz),
    .brightness(brightness), .abcdefg(abcdefg), .dot(dot), .anodes(anodes),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ND-1:0] an;
    logic [6:0]    seg;
    logic          dp;
    logic          fs;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int e = 0;                 // rising edges since reset release
  logic [4*ND-1:0] m_num;    // model snapshot registers
  logic [ND-1:0]   m_dots;
  logic            m_blz;

  function automatic logic [6:0] hex_seg(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
          7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
          7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
          7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    return t[n];
  endfunction

  task automatic chk_reset(input string tag);
    n_cmp++;
    assert (anodes === '1) else begin
      n_bad++; $error("FAIL %s anodes got %b want %b", tag, anodes, 4'hF);
    end
    n_cmp++;
    assert (abcdefg === 7'h7F) else begin
      n_bad++; $error("FAIL %s abcdefg got %b want %b", tag, abcdefg, 7'h7F);
    end
    n_cmp++;
    assert (dot === 1'b1) else begin
      n_bad++; $error("FAIL %s dot got %b want 1", tag, dot);
    end
    n_cmp++;
    assert (frame_start === 1'b0) else begin
      n_bad++; $error("FAIL %s frame_start got %b want 0", tag, frame_start);
    end
  endtask

  // Push the expectation for the next edge, clock once, then pop and compare.
  task automatic tick();
    exp_t x;
    int cn, ix;
    logic [3:0] nib;
    logic blank;
    cn = e % SLOT;
    ix = (e / SLOT) % ND;
    x.an  = ((cn >> (SW - BW)) <= int'(brightness)) ? ~(4'b0001 << ix) : 4'hF;
    nib   = m_num[4*ix +: 4];
    blank = m_blz && (ix > 0) && ((m_num >> (4*ix)) == 0);
    x.seg = blank ? 7'h7F : ~hex_seg(nib);
    x.dp  = ~m_dots[ix];
    x.fs  = ((e + 1) % FRAME == 0);
    sb.push_back(x);
    @(posedge clk);
    e++;
    if (e % FRAME == 0) begin
      m_num  = num;
      m_dots = dots;
      m_blz  = blank_lz;
    end
    @(negedge clk);
    x = sb.pop_front();
    n_cmp++;
    assert (anodes === x.an) else begin
      n_bad++; $error("FAIL anodes e=%0d got %b want %b", e, anodes, x.an);
    end
    n_cmp++;
    assert (abcdefg === x.seg) else begin
      n_bad++; $error("FAIL abcdefg e=%0d got %b want %b", e, abcdefg, x.seg);
    end
    n_cmp++;
    assert (dot === x.dp) else begin
      n_bad++; $error("FAIL dot e=%0d got %b want %b", e, dot, x.dp);
    end
    n_cmp++;
    assert (frame_start === x.fs) else begin
      n_bad++; $error("FAIL frame_start e=%0d got %b want %b", e, frame_start, x.fs);
    end
  endtask

  task automatic run_to(input int target);
    while (e < target) tick();
  endtask

  task automatic release_reset();
    reset  = 1'b0;
    e      = 0;
    m_num  = '0;
    m_dots = '0;
    m_blz  = 1'b0;
    sb.delete();
  endtask

  initial begin
    reset      = 1'b1;
    num        = 16'h12AF;
    dots       = 4'b0000;
    blank_lz   = 1'b0;
    brightness = 2'd3;
    repeat (3) @(negedge clk);
    chk_reset("reset_hold");
    release_reset();

    // Zeros until first snapshot at edge 64, then 12AF frame.
    run_to(2 * FRAME);

    // Leading-zero blanking on, then off.
    num      = 16'h0005;
    blank_lz = 1'b1;
    run_to(4 * FRAME);
    blank_lz = 1'b0;
    run_to(5 * FRAME);

    // PWM duty at brightness 0 and 2.
    num        = 16'h1111;
    brightness = 2'd0;
    run_to(6 * FRAME);
    brightness = 2'd2;
    run_to(7 * FRAME);
    brightness = 2'd3;

    // Change inputs while idx=2; display must hold until next snapshot.
    run_to(7 * FRAME + 2 * SLOT + 8);
    num = 16'h2222;
    run_to(9 * FRAME);

    // Dot on a blanked digit.
    dots     = 4'b0100;
    num      = 16'h0000;
    blank_lz = 1'b1;
    run_to(11 * FRAME);

    // Asynchronous reset mid-slot at idx=3, cnt=7.
    dots     = 4'b0000;
    blank_lz = 1'b0;
    num      = 16'h12AF;
    run_to(11 * FRAME + 3 * SLOT + 7);
    reset = 1'b1;
    #1;
    chk_reset("async_reset");
    @(negedge clk);
    chk_reset("reset_mid");
    release_reset();
    run_to(2 * FRAME + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seven_segment_mux.md
SEVEN_SEGMENT_MUX -- requirements
Module: seven_segment_mux

Interface
REQ-001 The module SHALL have parameter n_digits, default 8: number of multiplexed digits, 2..16.
REQ-002 The module SHALL have parameter strobe_width, default 10: digit slot length is 2^strobe_width clk cycles.
REQ-003 The module SHALL have parameter bright_width, default 3: brightness resolution, 1..strobe_width-1.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 The module SHALL have port num, input, 4*n_digits bits: hex nibbles; nibble i (bits 4i+3:4i) drives digit i; digit 0 is least significant.
REQ-007 The module SHALL have port dots, input, n_digits bits: dot request per digit.
REQ-008 The module SHALL have port blank_lz, input, 1 bit: leading-zero blanking enable.
REQ-009 The module SHALL have port brightness, input, bright_width bits: PWM duty select.
REQ-010 The module SHALL have port abcdefg, output, 7 bits, active-low: segments, bit 6 = a ... bit 0 = g.
REQ-011 The module SHALL have port dot, output, 1 bit, active-low: decimal point.
REQ-012 The module SHALL have port anodes, output, n_digits bits, active-low: digit select, at most one bit low.
REQ-013 The module SHALL have port frame_start, output, 1 bit: one-cycle pulse when a new frame snapshot is taken.

Function
REQ-014 The module SHALL keep a free-running slot counter cnt[strobe_width-1:0] that increments every cycle and wraps to 0.
REQ-015 On the cycle cnt is all ones, the module SHALL advance digit index idx by 1, wrapping from n_digits-1 to 0.
REQ-016 When idx wraps to 0, the module SHALL, on the same edge, load shadow registers from num, dots and blank_lz and assert frame_start for exactly that one cycle.
REQ-017 Inputs changing mid-frame SHALL NOT affect the display until the next snapshot (no tearing).
REQ-018 The module SHALL use a PWM gate pwm_on = (cnt[strobe_width-1 -: bright_width] <= brightness), giving a duty of (brightness+1)/2^bright_width; all ones gives 100%.
REQ-019 The module SHALL register outputs each cycle from the current idx/cnt; outputs SHALL lag idx by exactly 1 cycle.
REQ-020 When pwm_on is 1, anodes bit idx SHALL be 0 and all other bits 1; when pwm_on is 0, all anodes bits SHALL be 1.
REQ-021 The module SHALL decode segments as standard hex 0-F, active-high a..g: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111; the module SHALL output the bitwise inverse.
REQ-022 Digit i>0 SHALL be blanked (abcdefg=1111111) when shadow blank_lz=1 and shadow nibbles i..n_digits-1 are all 0; digit 0 SHALL never be blanked.
REQ-023 dot SHALL be the inverse of shadow dots[idx], independent of blanking.
REQ-024 When anodes are all 1 (PWM off), abcdefg and dot SHALL still carry the decoded values of the current digit.

Reset
REQ-025 While reset is 1, the module SHALL hold cnt=0, idx=0, shadow num=0, shadow dots=0, shadow blank_lz=0, anodes all 1, abcdefg=1111111, dot=1, frame_start=0.
REQ-026 After reset release, the module SHALL display shadow zeros (digit "0" on every slot, no dots) until the first snapshot at the first idx wrap, n_digits*2^strobe_width cycles later.
REQ-027 Reset asserted mid-frame SHALL immediately force the REQ-025 values, with no partial-slot completion.

Verification (n_digits=4, strobe_width=4, bright_width=2)
REQ-028 Reset, num=16'h12AF, dots=0, brightness=3 -> frame_start first at cycle 64; the next frame shows digit 0 (anodes=1110) abcdefg=0111000, digit 1 (1101) 0001000, digit 2 (1011) 0010010, digit 3 (0111) 1001111; each slot lasts 16 cycles.
REQ-029 num=16'h0005, blank_lz=1 -> digit 0 abcdefg=0100100; digits 1-3 abcdefg=1111111 while their anodes still pulse low; with blank_lz=0, digits 1-3 show 0000001.
REQ-030 brightness=0 -> in each 16-cycle slot the anode is low for exactly cycles cnt 0-3 (+1 cycle latency); brightness=2 -> low for 12 cycles.
REQ-031 Change num from 16'h1111 to 16'h2222 while idx=2 -> digits 2 and 3 still show 1 in that frame, and all digits show 2 after the next frame_start.
REQ-032 dots=4'b0100, num=0, blank_lz=1 -> during slot 2, abcdefg=1111111 and dot=0; during other slots, dot=1.
REQ-033 Assert reset at idx=3, cnt=7 -> anodes go to 1111 asynchronously without waiting for a clock edge; after release, cnt and idx restart from 0 and frame_start recurs at cycle 64.
